// File: rtl/console_out.sv
// Paced character sink: buffers writeback bytes in a circular FIFO and drains
// one byte every DRAIN_DIV cycles onto a registered character port.
module console_out #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [7:0]               wdata,
  input  logic                     halt_req,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     char_valid,
  output logic [7:0]               char_out,
  output logic                     done,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(DRAIN_DIV);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PACE_MAX = PW'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [PW-1:0] pace_reg;
  logic [PW-1:0] pace_next;
  state_t        state_reg;
  logic          full_reg;
  logic          char_valid_reg;
  logic [7:0]    char_out_reg;
  logic          done_reg;
  logic          overflow_reg;

  logic pop;
  logic accepting;
  logic push;
  logic drop;

  always_comb begin
    pop       = (count_reg != '0) && (pace_reg == PACE_MAX);
    accepting = (state_reg != S_DONE);
    // A full FIFO still takes a byte when the head leaves on the same edge.
    push      = accepting && wen && ((count_reg != DEPTH_C) || pop);
    drop      = accepting && wen && (count_reg == DEPTH_C) && !pop;

    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    pace_next = '0;
    if ((count_reg != '0) && !pop) begin
      pace_next = pace_reg + 1'b1;
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      pace_reg       <= '0;
      state_reg      <= S_RUN;
      full_reg       <= 1'b0;
      char_valid_reg <= 1'b0;
      char_out_reg   <= 8'h00;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      count_reg      <= count_next;
      pace_reg       <= pace_next;
      full_reg       <= (count_next == DEPTH_C);
      char_valid_reg <= pop;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        char_out_reg <= mem[rd_ptr_reg];
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        S_RUN: begin
          if (halt_req) begin
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Never finish on a pop edge, so the last byte is seen before done.
          if ((count_next == '0) && !wen && !pop) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_DONE;
        end
        default: begin
          state_reg <= S_RUN;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && pop) begin
      $write("%c", mem[rd_ptr_reg]);
    end
  end
`endif

  assign full       = full_reg;
  assign count      = count_reg;
  assign char_valid = char_valid_reg;
  assign char_out   = char_out_reg;
  assign done       = done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_console_out.sv
// Directed bench for console_out with default parameters (DEPTH=8, DRAIN_DIV=4).
// Edge numbers in the stimulus loops count from the first edge of each scenario.
module tb_console_out;

  logic       clk;
  logic       rst;
  logic       wen;
  logic [7:0] wdata;
  logic       halt_req;
  logic       full;
  logic [3:0] count;
  logic       char_valid;
  logic [7:0] char_out;
  logic       done;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int pop_idx;
  logic exp_v;
  logic stray;

  console_out #(.DEPTH(8), .DRAIN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .wdata      (wdata),
    .halt_req   (halt_req),
    .full       (full),
    .count      (count),
    .char_valid (char_valid),
    .char_out   (char_out),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (char_valid === 1'b1) begin
      $display("pop char=%02h count=%0d done=%0b", char_out, count, done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wen = 1'b0; halt_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; wdata = 8'h00; halt_req = 1'b0;

    // 1: reset with wen and halt_req held high
    rst = 1'b1; wen = 1'b1; halt_req = 1'b1; wdata = 8'hAA;
    tick();
    tick();
    check("t1_full", full, 0);
    check("t1_count", count, 0);
    check("t1_valid", char_valid, 0);
    check("t1_char", char_out, 8'h00);
    check("t1_done", done, 0);
    check("t1_ovf", overflow, 0);
    rst = 1'b0; wen = 1'b0; halt_req = 1'b0;

    // 2: single byte latency
    wen = 1'b1; wdata = 8'h48;
    tick();
    wen = 1'b0;
    check("t2_count_e0", count, 1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t2_count_e%0d", e), count, 1);
      check($sformatf("t2_valid_e%0d", e), char_valid, 0);
    end
    tick();
    check("t2_valid_e4", char_valid, 1);
    check("t2_char_e4", char_out, 8'h48);
    check("t2_count_e4", count, 0);
    tick();
    check("t2_valid_e5", char_valid, 0);
    check("t2_hold_e5", char_out, 8'h48);

    // 3: overflow burst of 12 writes
    do_reset();
    pop_idx = 0;
    for (int e = 0; e < 48; e++) begin
      wen = (e < 12); wdata = 8'h41 + 8'(e);
      tick();
      exp_v = (e >= 4) && (e % 4 == 0) && (e <= 40);
      check($sformatf("t3_valid_e%0d", e), char_valid, exp_v);
      if (exp_v) begin
        check($sformatf("t3_char_%0d", pop_idx), char_out, 8'h41 + pop_idx);
        pop_idx++;
      end
      if (e == 8)  check("t3_full_e8", full, 0);
      if (e == 9)  check("t3_full_e9", full, 1);
      if (e == 9)  check("t3_count_e9", count, 8);
      if (e == 9)  check("t3_ovf_e9", overflow, 0);
      if (e == 10) check("t3_ovf_e10", overflow, 1);
    end
    wen = 1'b0;
    check("t3_pops", pop_idx, 10);
    check("t3_count_end", count, 0);
    check("t3_ovf_end", overflow, 1);

    // 4: push while full on a pop edge
    do_reset();
    pop_idx = 0;
    for (int e = 0; e < 48; e++) begin
      wen = (e <= 9) || (e == 12);
      wdata = (e == 12) ? 8'h5A : 8'h61 + 8'(e);
      tick();
      exp_v = (e >= 4) && (e % 4 == 0) && (e <= 44);
      check($sformatf("t4_valid_e%0d", e), char_valid, exp_v);
      if (exp_v) begin
        check($sformatf("t4_char_%0d", pop_idx), char_out,
              (pop_idx < 10) ? 8'h61 + pop_idx : 8'h5A);
        pop_idx++;
      end
      if (e == 9)  check("t4_count_e9", count, 8);
      if (e == 12) check("t4_count_e12", count, 8);
      if (e == 12) check("t4_full_e12", full, 1);
    end
    wen = 1'b0;
    check("t4_pops", pop_idx, 11);
    check("t4_ovf_end", overflow, 0);

    // 5: halt drain with a late write
    do_reset();
    pop_idx = 0;
    for (int e = 0; e <= 17; e++) begin
      wen = (e <= 2) || (e == 5);
      wdata = (e == 5) ? 8'h34 : 8'h31 + 8'(e);
      halt_req = (e == 3);
      tick();
      exp_v = (e >= 4) && (e % 4 == 0);
      check($sformatf("t5_valid_e%0d", e), char_valid, exp_v);
      if (exp_v) begin
        check($sformatf("t5_char_%0d", pop_idx), char_out, 8'h31 + pop_idx);
        pop_idx++;
      end
      if (e == 16) check("t5_done_e16", done, 0);
      if (e == 17) check("t5_done_e17", done, 1);
    end
    halt_req = 1'b0;
    check("t5_pops", pop_idx, 4);
    wen = 1'b1; wdata = 8'h39;
    for (int e = 0; e < 3; e++) tick();
    wen = 1'b0;
    check("t5_count_after_done", count, 0);
    check("t5_ovf_after_done", overflow, 0);
    check("t5_done_sticky", done, 1);

    // 6: reset in the middle of a drain
    do_reset();
    pop_idx = 0;
    for (int e = 0; e <= 8; e++) begin
      wen = (e <= 4); wdata = 8'h70 + 8'(e);
      halt_req = (e == 5);
      tick();
      exp_v = (e == 4) || (e == 8);
      check($sformatf("t6_valid_e%0d", e), char_valid, exp_v);
      if (exp_v) begin
        check($sformatf("t6_char_%0d", pop_idx), char_out, 8'h70 + pop_idx);
        pop_idx++;
      end
    end
    do_reset();
    check("t6_count_rst", count, 0);
    check("t6_valid_rst", char_valid, 0);
    check("t6_char_rst", char_out, 8'h00);
    check("t6_done_rst", done, 0);
    stray = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (char_valid !== 1'b0) stray = 1'b1;
    end
    check("t6_no_stray_pop", stray, 0);
    check("t6_still_run", done, 0);
    for (int e = 0; e <= 5; e++) begin
      wen = (e == 0); wdata = 8'h21;
      tick();
      check($sformatf("t6_new_valid_e%0d", e), char_valid, e == 4);
      if (e == 4) check("t6_new_char", char_out, 8'h21);
    end
    wen = 1'b0;

    // halt on an empty FIFO: DRAIN then DONE one edge later
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("t7_done_k", done, 0);
    tick();
    check("t7_done_k1", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_out.md
# console_out

Character output sink for the pipelined core. It accepts byte writes from the writeback stage (writes to r0, excluding jumps and stores) and buffers them in a FIFO. Bytes drain at a fixed, paced rate onto a registered character port, and each one is echoed to the simulation console. On halt it empties the buffer and raises `done` before the testbench ends the run.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `DRAIN_DIV`, default 4: cycles between successive pops; minimum 2.

Ports:
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset, synchronous and active-high.
- `wen`  in  1: write strobe, one byte per cycle.
- `wdata`  in  8: byte to enqueue; sampled when `wen`=1.
- `halt_req`  in  1: core has halted; level or pulse.
- `full`  out  1: `count`==`DEPTH`.
- `count`  out  log2(DEPTH)+1: current occupancy.
- `char_valid`  out  1: one-cycle pulse per popped byte.
- `char_out`  out  8: popped byte; holds its last value between pulses.
- `done`  out  1: drain complete; sticky until `rst`.
- `overflow`  out  1: sticky; set when a write is dropped.

## Operation
- **Storage:** circular buffer with read pointer, write pointer and an occupancy counter. Pointers wrap modulo `DEPTH`.
- **Push:** accepted when `wen`=1 and either `count`<`DEPTH` or a pop occurs on the same edge.
  - If full with no pop on that edge, the byte is dropped and `overflow` is set to 1.
  - Push and pop on the same edge leave `count` unchanged.
- **Pacing counter `pace`** (0..`DRAIN_DIV`-1):
  - Held at 0 while `count`==0.
  - Otherwise increments each cycle.
  - When `pace`==`DRAIN_DIV`-1 and `count`>0: pop the head byte, set `pace` to 0, drive `char_out`=head and `char_valid`=1 for one cycle, and `$write("%c", head)`.
- **FSM** (states RUN, DRAIN, DONE):
  - RUN: normal operation. `halt_req`=1 moves to DRAIN.
  - DRAIN: pushes are still accepted, because in-flight writebacks may arrive after the halt. Pacing is unchanged. Moves to DONE on the first edge where `count`==0 after the edge and `wen`=0.
  - DONE: `done`=1. `wen` is ignored: no push, and `overflow` is not affected. Remains in DONE until `rst`.
- **Reset** (`rst`=1 at posedge), from any state including mid-drain:
  - Pointers, `count` and `pace` go to 0; state goes to RUN.
  - `full`=0, `char_valid`=0, `char_out`=8'h00, `done`=0, `overflow`=0.
  - Buffered bytes are discarded without being printed.
  - `rst` has priority over `wen` and `halt_req` on the same edge.

## Timing
- All outputs are registered.
- `count` and `full` reflect the state after the most recent edge.
- **Latency:** write accepted at edge k into an empty FIFO gives a pop at edge k+`DRAIN_DIV`. `char_valid` is high between edges k+`DRAIN_DIV` and k+`DRAIN_DIV`+1.
- **Throughput:** with the FIFO continuously non-empty, one byte every `DRAIN_DIV` cycles. Output order equals accept order.
- **Halt on an empty FIFO:** `halt_req`=1 with `count`=0 and `wen`=0 at edge k gives RUN→DRAIN at edge k, then DRAIN→DONE at edge k+1. `done` is first seen after edge k+1.
- **DONE timing:** the DRAIN→DONE edge is never the same edge as a pop's `char_valid` assertion edge. DONE is entered the edge after the last pop at the earliest.

## Test plan
1. **Reset values:** assert `rst` for 2 cycles with `wen`=1 and `halt_req`=1 held. Required: every output 0 (including `char_out`=8'h00), `count`=0, no console output.
2. **Single byte:** write 8'h48 at edge 0, defaults. Required:
   - `count`=1 for edges 0–3.
   - `char_valid`=1 with `char_out`=8'h48 only after edge 4.
   - `count`=0 after edge 4; console shows "H".
3. **Overflow burst:** 12 consecutive writes 8'h41..8'h4C starting at edge 0, defaults. Required:
   - Pops at edges 4, 8, 12, …
   - `full`=1 after edge 9.
   - 8'h4B and 8'h4C dropped; `overflow`=1 from edge 10.
   - Output sequence exactly "ABCDEFGHIJ".
4. **Push while full at pop edge:** fill to 8 with `pace` aligned so that edge N pops, then write 8'h5A at edge N. Required: accepted, `count` stays 8, `overflow` stays 0, 8'h5A is the last byte out.
5. **Halt drain:** enqueue 3 bytes, assert `halt_req` 1 cycle, then write 1 more byte during DRAIN. Required:
   - All 4 bytes are output.
   - `done` rises the edge after the 4th pop.
   - `wen` after `done` changes neither `count` nor `overflow`.
6. **Reset mid-drain:** enqueue 5 bytes, assert `halt_req`, then `rst` after the 2nd pop. Required: the remaining 3 bytes are never output, state is RUN, `done`=0, and a new write at edge 0 after reset pops at edge 4.
